// File: rtl/ddr3_app_arbiter_if.sv
// Command-port bundle between the write/read address controllers, the arbiter
// and the MIG user command port. The master modport is the arbiter's view.
interface ddr3_app_arbiter_if;
  logic        wr_app_en;
  logic [25:0] ddr3_wr_addr;
  logic        wr_app_rdy;
  logic        rd_app_en;
  logic [25:0] ddr3_rd_addr;
  logic        rd_app_rdy;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [25:0] app_addr;
  logic        app_rdy;

  modport master (
    input  wr_app_en, ddr3_wr_addr, rd_app_en, ddr3_rd_addr, app_rdy,
    output wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr
  );

  modport slave (
    output wr_app_en, ddr3_wr_addr, rd_app_en, ddr3_rd_addr, app_rdy,
    input  wr_app_rdy, rd_app_rdy, app_en, app_cmd, app_addr
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// Two-requester arbiter for the DDR3 MIG command port: quota/idle-based grant
// switching with one turnaround cycle. Define DDR3_ARB_STATS_EN for command counters.
module ddr3_app_arbiter #(
  parameter int QUOTA    = 16,
  parameter int IDLE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  ddr3_app_arbiter_if.master  bus,
  output logic                gnt_wr,
  output logic                gnt_rd,
  output logic [31:0]         wr_cmd_cnt,
  output logic [31:0]         rd_cmd_cnt
);

  localparam logic [7:0] QUOTA_C = 8'(QUOTA);
  localparam logic [7:0] IDLE_C  = 8'(IDLE_CYC);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    GNT_WR = 4'b0010,
    GNT_RD = 4'b0100,
    TURN   = 4'b1000
  } state_t;

  state_t     state_reg, state_next;
  logic       next_rd_reg, next_rd_next;
  logic       wr_pend_reg, wr_pend_next;
  logic       rd_pend_reg, rd_pend_next;
  logic [7:0] quota_cnt_reg, quota_cnt_next;
  logic [7:0] idle_cnt_reg, idle_cnt_next;
  logic [7:0] quota_inc, idle_inc;
  logic       accepted, grant_entry;

  assign gnt_wr         = (state_reg == GNT_WR);
  assign gnt_rd         = (state_reg == GNT_RD);
  assign bus.app_en     = (gnt_wr & bus.wr_app_en) | (gnt_rd & bus.rd_app_en);
  assign bus.app_cmd    = gnt_rd ? 3'b001 : 3'b000;
  assign bus.app_addr   = gnt_rd ? bus.ddr3_rd_addr : bus.ddr3_wr_addr;
  assign bus.wr_app_rdy = gnt_wr & bus.app_rdy;
  assign bus.rd_app_rdy = gnt_rd & bus.app_rdy;
  assign accepted       = bus.app_en & bus.app_rdy;

  // Switch decisions look at the post-update counters so the grant ends on the
  // same edge the quota or idle limit is reached.
  assign quota_inc = (quota_cnt_reg == QUOTA_C) ? quota_cnt_reg : quota_cnt_reg + {7'd0, accepted};
  assign idle_inc  = bus.app_en ? 8'd0 :
                     ((idle_cnt_reg == IDLE_C) ? idle_cnt_reg : idle_cnt_reg + 8'd1);

  always_comb begin
    state_next   = state_reg;
    next_rd_next = next_rd_reg;
    case (state_reg)
      IDLE: begin
        if (bus.wr_app_en | wr_pend_reg)      state_next = GNT_WR;
        else if (bus.rd_app_en | rd_pend_reg) state_next = GNT_RD;
      end
      GNT_WR: begin
        if (rd_pend_reg && (quota_inc == QUOTA_C || idle_inc == IDLE_C)) begin
          state_next   = TURN;
          next_rd_next = 1'b1;
        end
      end
      GNT_RD: begin
        if (wr_pend_reg && (quota_inc == QUOTA_C || idle_inc == IDLE_C)) begin
          state_next   = TURN;
          next_rd_next = 1'b0;
        end
      end
      TURN:    state_next = next_rd_reg ? GNT_RD : GNT_WR;
      default: state_next = IDLE;
    endcase

    grant_entry = (state_next == GNT_WR || state_next == GNT_RD) && (state_next != state_reg);

    wr_pend_next = wr_pend_reg | (bus.wr_app_en & (state_reg != GNT_WR));
    if (state_next == GNT_WR && state_reg != GNT_WR) wr_pend_next = 1'b0;
    rd_pend_next = rd_pend_reg | (bus.rd_app_en & (state_reg != GNT_RD));
    if (state_next == GNT_RD && state_reg != GNT_RD) rd_pend_next = 1'b0;

    quota_cnt_next = grant_entry ? 8'd0 : quota_inc;
    idle_cnt_next  = grant_entry ? 8'd0 : idle_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      next_rd_reg   <= 1'b0;
      wr_pend_reg   <= 1'b0;
      rd_pend_reg   <= 1'b0;
      quota_cnt_reg <= 8'd0;
      idle_cnt_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      next_rd_reg   <= next_rd_next;
      wr_pend_reg   <= wr_pend_next;
      rd_pend_reg   <= rd_pend_next;
      quota_cnt_reg <= quota_cnt_next;
      idle_cnt_reg  <= idle_cnt_next;
    end
  end

`ifdef DDR3_ARB_STATS_EN
  // Index 0 counts write acceptances, index 1 read acceptances.
  logic [1:0]  acc_vec;
  logic [31:0] cmd_cnt_reg [2];

  assign acc_vec = {bus.rd_app_en & bus.rd_app_rdy, bus.wr_app_en & bus.wr_app_rdy};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    always_ff @(posedge clk) begin
      if (reset)            cmd_cnt_reg[gi] <= 32'd0;
      else if (acc_vec[gi]) cmd_cnt_reg[gi] <= cmd_cnt_reg[gi] + 32'd1;
    end
  end

  assign wr_cmd_cnt = cmd_cnt_reg[0];
  assign rd_cmd_cnt = cmd_cnt_reg[1];
`else
  assign wr_cmd_cnt = 32'd0;
  assign rd_cmd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter: a behavioural arbitration model pushes
// expected per-cycle port values; a negedge monitor pops and compares them.
module tb_ddr3_app_arbiter;
  localparam int QUOTA    = 16;
  localparam int IDLE_CYC = 4;
`ifdef DDR3_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gnt_wr, gnt_rd;
  logic [31:0] wr_cmd_cnt, rd_cmd_cnt;

  always #5 clk = ~clk;

  ddr3_app_arbiter_if bus ();

  ddr3_app_arbiter #(.QUOTA(QUOTA), .IDLE_CYC(IDLE_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .gnt_wr     (gnt_wr),
    .gnt_rd     (gnt_rd),
    .wr_cmd_cnt (wr_cmd_cnt),
    .rd_cmd_cnt (rd_cmd_cnt)
  );

  typedef struct {
    bit        gw, gr, en, wrdy, rrdy;
    bit [2:0]  cmd;
    bit [25:0] addr;
    bit [31:0] wc, rc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Requester agents and MIG readiness knobs
  int wr_left = 0, rd_left = 0, wr_pct = 100, rd_pct = 100, rdy_pct = 100;

  // Reference model: owner 0 = nobody, 1 = writer, 2 = reader, 3 = changing hands
  int        m_owner = 0, m_target = 0, m_served = 0, m_idle = 0;
  bit        m_wpend = 0, m_rpend = 0, m_acc_wr = 0, m_acc_rd = 0;
  bit [31:0] m_wc = 0, m_rc = 0;

  // Quota observation for the simultaneous-request scenario
  bit q_watch = 0;
  int q_wr = 0;

  function automatic void model_eval();
    exp_t e;
    bit   w_own = (m_owner == 1);
    bit   r_own = (m_owner == 2);
    e.gw   = w_own;
    e.gr   = r_own;
    e.en   = (w_own && bus.wr_app_en) || (r_own && bus.rd_app_en);
    e.cmd  = r_own ? 3'd1 : 3'd0;
    e.addr = r_own ? bus.ddr3_rd_addr : bus.ddr3_wr_addr;
    e.wrdy = w_own && bus.app_rdy;
    e.rrdy = r_own && bus.app_rdy;
    e.wc   = STATS ? m_wc : 32'd0;
    e.rc   = STATS ? m_rc : 32'd0;
    m_acc_wr = w_own && bus.wr_app_en && bus.app_rdy;
    m_acc_rd = r_own && bus.rd_app_en && bus.app_rdy;
    exp_q.push_back(e);
  endfunction

  function automatic void model_commit();
    int served_new, idle_new, nxt;
    bit owner_busy;
    if (reset) begin
      m_owner = 0; m_target = 0; m_served = 0; m_idle = 0;
      m_wpend = 0; m_rpend = 0; m_wc = 0; m_rc = 0;
      return;
    end
    owner_busy = (m_owner == 1 && bus.wr_app_en) || (m_owner == 2 && bus.rd_app_en);
    served_new = m_served + ((m_acc_wr || m_acc_rd) ? 1 : 0);
    if (served_new > QUOTA) served_new = QUOTA;
    idle_new = owner_busy ? 0 : ((m_idle + 1 > IDLE_CYC) ? IDLE_CYC : m_idle + 1);
    nxt = m_owner;
    if (m_owner == 0) begin
      if (bus.wr_app_en || m_wpend)      nxt = 1;
      else if (bus.rd_app_en || m_rpend) nxt = 2;
    end else if (m_owner == 3) begin
      nxt = m_target;
    end else begin
      bit other_waiting = (m_owner == 1) ? m_rpend : m_wpend;
      if (other_waiting && (served_new == QUOTA || idle_new == IDLE_CYC)) begin
        nxt = 3;
        m_target = (m_owner == 1) ? 2 : 1;
      end
    end
    if (bus.wr_app_en && m_owner != 1) m_wpend = 1;
    if (bus.rd_app_en && m_owner != 2) m_rpend = 1;
    if (nxt == 1 && m_owner != 1) m_wpend = 0;
    if (nxt == 2 && m_owner != 2) m_rpend = 0;
    if ((nxt == 1 || nxt == 2) && nxt != m_owner) begin
      m_served = 0; m_idle = 0;
    end else begin
      m_served = served_new; m_idle = idle_new;
    end
    if (m_acc_wr) m_wc = m_wc + 1;
    if (m_acc_rd) m_rc = m_rc + 1;
    m_owner = nxt;
  endfunction

  task automatic agents();
    if (m_acc_wr) begin wr_left--; bus.wr_app_en = 1'b0; end
    if (m_acc_rd) begin rd_left--; bus.rd_app_en = 1'b0; end
    if (!bus.wr_app_en && wr_left > 0 && $urandom_range(99) < wr_pct) begin
      bus.wr_app_en    = 1'b1;
      bus.ddr3_wr_addr = 26'($urandom);
    end
    if (!bus.rd_app_en && rd_left > 0 && $urandom_range(99) < rd_pct) begin
      bus.rd_app_en    = 1'b1;
      bus.ddr3_rd_addr = 26'($urandom);
    end
    bus.app_rdy = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_eval();
      @(posedge clk);
      #1;
      model_commit();
      agents();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (gnt_wr !== e.gw || gnt_rd !== e.gr || bus.app_en !== e.en || bus.app_cmd !== e.cmd ||
          bus.app_addr !== e.addr || bus.wr_app_rdy !== e.wrdy || bus.rd_app_rdy !== e.rrdy ||
          wr_cmd_cnt !== e.wc || rd_cmd_cnt !== e.rc) begin
        miscompares++;
        $display("FAIL port_cycle t=%0t actual gw=%b gr=%b en=%b cmd=%0d addr=%h wrdy=%b rrdy=%b wc=%0d rc=%0d required gw=%b gr=%b en=%b cmd=%0d addr=%h wrdy=%b rrdy=%b wc=%0d rc=%0d",
                 $time, gnt_wr, gnt_rd, bus.app_en, bus.app_cmd, bus.app_addr, bus.wr_app_rdy,
                 bus.rd_app_rdy, wr_cmd_cnt, rd_cmd_cnt, e.gw, e.gr, e.en, e.cmd, e.addr,
                 e.wrdy, e.rrdy, e.wc, e.rc);
      end
      if (bus.app_en === 1'b1 && bus.app_rdy === 1'b1)
        $display("t=%0t accept %s addr=%h", $time, (bus.app_cmd == 3'd1) ? "rd" : "wr", bus.app_addr);
      if (q_watch) begin
        if (bus.wr_app_en && bus.wr_app_rdy) q_wr++;
        if (gnt_rd) begin
          vectors++;
          if (q_wr != QUOTA) begin
            miscompares++;
            $display("FAIL quota_writes actual=%0d required=%0d", q_wr, QUOTA);
          end
          q_watch = 0;
        end
      end
    end
  end

  initial begin
    int budget;
    bus.wr_app_en = 1'b0; bus.rd_app_en = 1'b0;
    bus.ddr3_wr_addr = '0; bus.ddr3_rd_addr = '0;
    bus.app_rdy = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters rise together in IDLE; writer first, then quota hand-over
    wr_left = 60; rd_left = 60; wr_pct = 100; rd_pct = 100; rdy_pct = 100;
    do_reset(3);
    q_wr = 0; q_watch = 1;
    step(60);
    if (q_watch) begin
      vectors++; miscompares++; q_watch = 0;
      $display("FAIL quota_handover actual=no_read_grant required=read_grant_after_%0d_writes", QUOTA);
    end

    // Owner goes idle while the reader waits
    wr_left = 3; rd_left = 0;
    do_reset(2);
    step(2);
    rd_left = 6;
    step(30);

    // MIG back-pressure during a read grant, then reset mid-grant
    wr_left = 0; rd_left = 50;
    do_reset(2);
    step(5);
    wr_left = 5;
    rdy_pct = 0;
    step(10);
    rdy_pct = 100;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(40);

    // Exactly 100 writes and 37 reads with random gaps and back-pressure
    wr_left = 0; rd_left = 0;
    do_reset(2);
    wr_left = 100; rd_left = 37; wr_pct = 60; rd_pct = 40; rdy_pct = 80;
    budget = 0;
    while ((wr_left > 0 || rd_left > 0) && budget < 4000) begin
      step(1);
      budget++;
    end
    vectors++;
    if (budget >= 4000) begin
      miscompares++;
      $display("FAIL stats_budget actual=wr_left_%0d_rd_left_%0d required=0_0", wr_left, rd_left);
    end
    vectors++;
    if (wr_cmd_cnt !== (STATS ? 32'd100 : 32'd0) || rd_cmd_cnt !== (STATS ? 32'd37 : 32'd0)) begin
      miscompares++;
      $display("FAIL stats_count actual=%0d/%0d required=%0d/%0d", wr_cmd_cnt, rd_cmd_cnt,
               STATS ? 100 : 0, STATS ? 37 : 0);
    end
    step(5);

    // Long random run with occasional resets
    wr_left = 100000; rd_left = 100000;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        wr_pct = $urandom_range(20, 100);
        rd_pct = $urandom_range(20, 100);
        rdy_pct = $urandom_range(40, 100);
      end
      reset = ($urandom_range(199) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ddr3_app_arbiter.md
# ddr3_app_arbiter

Shares the single DDR3 MIG user command port (`app_en`/`app_cmd`/`app_addr`/`app_rdy`) between two requesters:
- the write-address path (`wr_app_en`, `ddr3_wr_addr`, `wr_app_rdy`);
- a read-address path (`rd_app_en`, `ddr3_rd_addr`, `rd_app_rdy`).

It sits between those controllers and the MIG command port. It grants the port to one requester at a time, enforces a per-grant command quota with a one-cycle turnaround, and forwards commands combinationally while a grant is held, so a granted requester sees MIG `app_rdy` in the same cycle.

## Interface
- `QUOTA`, default 16: maximum accepted commands per grant when the other side is waiting; range 1..255.
- `IDLE_CYC`, default 4: consecutive cycles without owner `*_app_en` before yielding to a waiting requester; range 1..255.

Ports:
- `clk`  in  1  DDR3 user-interface clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `wr_app_en`  in  1  write-command request.
- `ddr3_wr_addr`  in  26  write address.
- `wr_app_rdy`  out  1  write command accepted this cycle.
- `rd_app_en`  in  1  read-command request.
- `ddr3_rd_addr`  in  26  read address.
- `rd_app_rdy`  out  1  read command accepted this cycle.
- `app_en`  out  1  MIG command valid.
- `app_cmd`  out  3  3'b000 write, 3'b001 read.
- `app_addr`  out  26  MIG address.
- `app_rdy`  in  1  MIG accepts command.
- `gnt_wr`  out  1  registered grant status, write path.
- `gnt_rd`  out  1  registered grant status, read path.
- `wr_cmd_cnt`  out  32  accepted write commands; stats only.
- `rd_cmd_cnt`  out  32  accepted read commands; stats only.

## Operation
- States: IDLE, GNT_WR, GNT_RD, TURN. Encoding is one-hot, registered.
- Outputs are combinational on the registered state:
  - `gnt_wr` = state==GNT_WR; `gnt_rd` = state==GNT_RD.
  - `app_en` = (`gnt_wr`&`wr_app_en`) | (`gnt_rd`&`rd_app_en`).
  - `app_cmd` = `gnt_rd` ? 3'b001 : 3'b000; `app_addr` = `gnt_rd` ? `ddr3_rd_addr` : `ddr3_wr_addr`.
  - `wr_app_rdy` = `gnt_wr`&`app_rdy`; `rd_app_rdy` = `gnt_rd`&`app_rdy`.
- Acceptance: a command is accepted when (`*_app_en` & `*_app_rdy`). A non-granted requester sees rdy=0 and must hold or retry its request.
- Pending flags:
  - `wr_pend` is set when `wr_app_en` is seen while not in GNT_WR, and cleared on entry to GNT_WR.
  - `rd_pend` is the mirror of `wr_pend` for the read path.
- `quota_cnt` (8 bit): cleared on grant entry, +1 per accepted command, saturates at QUOTA.
- `idle_cnt` (8 bit): cleared when the owner's en=1, +1 otherwise, saturates at IDLE_CYC.
- Transitions:
  - IDLE: `wr_app_en`|`wr_pend` → GNT_WR. Otherwise `rd_app_en`|`rd_pend` → GNT_RD. Otherwise stay. Write wins simultaneous requests.
  - GNT_WR: `rd_pend` & (quota_cnt==QUOTA | idle_cnt==IDLE_CYC) → TURN with `next_rd`=1. Otherwise stay, parked on owner.
  - GNT_RD: mirror of GNT_WR, with `next_rd`=0.
  - TURN: → GNT_RD if `next_rd`, else GNT_WR. TURN holds no grant, so no command is accepted.
- A command accepted in the same cycle the quota saturates is valid. The switch occurs on the next edge.
- Reset mid-operation returns to IDLE and drops any grant in the same edge. A requester whose command was not accepted retries.

## Timing
- Reset values:
  - state IDLE; `gnt_wr`=`gnt_rd`=0.
  - `app_en`=0, `wr_app_rdy`=`rd_app_rdy`=0.
  - `app_cmd`=3'b000; `app_addr` follows `ddr3_wr_addr`.
  - pend flags, quota_cnt, idle_cnt and stats counters all 0.
- Grant latency from IDLE: a request at cycle N gives the grant at N+1, and the first acceptance is possible at N+1.
- Switch latency after the switch condition is met at cycle N: TURN at N+1, new grant at N+2.
- Pass-through is zero-cycle: `app_en` follows `*_app_en` with no register. The requester must keep en/addr stable until its rdy=1.
- Worst-case wait for a waiting requester is QUOTA + 2 cycles after its request, provided MIG `app_rdy` stays asserted.

## Configuration
- `DDR3_ARB_STATS_EN` defined:
  - `wr_cmd_cnt` increments on each accepted write command; `rd_cmd_cnt` increments on each accepted read command.
  - Both are 32-bit and wrap 0xFFFFFFFF→0; `reset` clears them.
- Not defined: `wr_cmd_cnt` and `rd_cmd_cnt` are tied to 0 and no counter logic is built.

## Test plan
- Reset with `wr_app_en`=1, then release reset at cycle 0:
  - `gnt_wr`=1 at cycle 1; with `app_rdy`=1, `app_en`=1, `app_cmd`=000 and `wr_app_rdy`=1 at cycle 1.
- `wr_app_en` and `rd_app_en` rise together in IDLE:
  - GNT_WR first.
  - With QUOTA=16, `app_rdy`=1 and continuous write requests: exactly 16 writes are accepted, then one TURN cycle, then `gnt_rd`=1 and `app_cmd`=001.
- Owner idle: in GNT_WR, `wr_app_en` goes low while `rd_app_en`=1 (IDLE_CYC=4):
  - switch to TURN after 4 idle cycles, then GNT_RD; no read accepted before then.
- MIG back-pressure: `app_rdy`=0 for 10 cycles during GNT_RD:
  - `rd_app_rdy`=0, quota_cnt unchanged, no switch by quota; acceptance resumes when `app_rdy` returns.
- Reset asserted during GNT_RD:
  - next edge IDLE, `gnt_rd`=0, `app_en`=0.
  - Stats counters clear when `DDR3_ARB_STATS_EN` is defined; they read 0 throughout when it is not defined.
- With `DDR3_ARB_STATS_EN` defined, 100 writes and 37 reads accepted:
  - `wr_cmd_cnt`=100, `rd_cmd_cnt`=37.
